// File: rtl/iarray_portarb_pkg.sv
// Shared constants and helpers for the iarray port arbiter.
package iarray_portarb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int IDBIT_DEF   = 2;
  localparam int ADDRBIT_DEF = 6;
  localparam int DEPTH_DEF   = 48;
  localparam int WIDTH_DEF   = 80;
  localparam int RDLAT_DEF   = 2;

  // Increment modulo n; used to advance the round-robin pointer past the winner.
  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/iarray_portarb_if.sv
// Requester-side and RAM-side signals of one shared array port.
interface iarray_portarb_if #(
  parameter int NREQ    = 4,
  parameter int IDBIT   = 2,
  parameter int ADDRBIT = 6,
  parameter int WIDTH   = 80
) ();
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         rwr;
  logic [NREQ*ADDRBIT-1:0] radr;
  logic [NREQ*WIDTH-1:0]   rdi;
  logic                    hold;
  logic [NREQ-1:0]         gnt;
  logic                    rvld;
  logic [IDBIT-1:0]        rid;
  logic [WIDTH-1:0]        rdat;
  logic                    err;
  logic [ADDRBIT-1:0]      ram_a;
  logic                    ram_we;
  logic                    ram_re;
  logic [WIDTH-1:0]        ram_di;
  logic [WIDTH-1:0]        ram_do;

  // Clients plus the RAM wrapper: drive requests and return RAM data.
  modport master (
    output req, rwr, radr, rdi, hold, ram_do,
    input  gnt, rvld, rid, rdat, err, ram_a, ram_we, ram_re, ram_di
  );

  // The arbiter itself.
  modport slave (
    input  req, rwr, radr, rdi, hold, ram_do,
    output gnt, rvld, rid, rdat, err, ram_a, ram_we, ram_re, ram_di
  );
endinterface

// File: rtl/iarray_portarb_rrpick.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module iarray_rrpick #(
  parameter int NREQ  = 4,
  parameter int IDBIT = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDBIT-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDBIT-1:0] id,
  output logic             any
);

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    id  = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        id       = IDBIT'(idx);
      end
    end
  end

endmodule

// File: rtl/iarray_portarb.sv
// Round-robin arbiter sharing one registered-output RAM port among NREQ
// requesters; issues one command per cycle and tags read returns by id.
module iarray_portarb
  import iarray_portarb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int IDBIT   = IDBIT_DEF,
  parameter int ADDRBIT = ADDRBIT_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int RDLAT   = RDLAT_DEF
) (
  input logic clk,
  input logic rst,
  iarray_portarb_if.slave bus
);

  logic [NREQ-1:0]        pick_gnt;
  logic [IDBIT-1:0]       pick_id;
  logic                   pick_any;
  logic                   grant;
  logic [ADDRBIT-1:0]     win_adr;
  logic [WIDTH-1:0]       win_di;
  logic                   win_wr;
  logic                   win_legal;

  logic [IDBIT-1:0]       ptr_q, ptr_d;
  logic [ADDRBIT-1:0]     a_q, a_d;
  logic [WIDTH-1:0]       di_q, di_d;
  logic                   we_q, we_d;
  logic                   re_q, re_d;
  logic                   err_q, err_d;
  // Latency pipe: stage k holds a read issued k+1 cycles ago by the grant.
  logic [RDLAT:0]             pv_q, pv_d;
  logic [RDLAT:0][IDBIT-1:0]  pid_q, pid_d;

  iarray_rrpick #(.NREQ(NREQ), .IDBIT(IDBIT)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .id  (pick_id),
    .any (pick_any)
  );

  // Grants are suppressed while quiesced or held in reset.
  assign grant   = pick_any & ~bus.hold & ~rst;
  assign bus.gnt = grant ? pick_gnt : '0;

  // Select the winner's command fields and check its address range.
  always_comb begin
    win_adr   = bus.radr[int'(pick_id)*ADDRBIT +: ADDRBIT];
    win_di    = bus.rdi[int'(pick_id)*WIDTH +: WIDTH];
    win_wr    = bus.rwr[pick_id];
    win_legal = int'(win_adr) < DEPTH;
  end

  // Next-state for pointer, command flops, error pulse and latency pipe.
  always_comb begin
    ptr_d    = ptr_q;
    a_d      = a_q;
    di_d     = di_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    err_d    = 1'b0;
    pv_d     = '0;
    pid_d    = '0;
    for (int k = 1; k <= RDLAT; k++) begin
      pv_d[k]  = pv_q[k-1];
      pid_d[k] = pid_q[k-1];
    end
    if (grant) begin
      ptr_d = IDBIT'(wrap_inc(int'(pick_id), NREQ));
      a_d   = win_adr;
      di_d  = win_di;
      if (win_legal) begin
        we_d = win_wr;
        re_d = ~win_wr;
        if (!win_wr) begin
          pv_d[0]  = 1'b1;
          pid_d[0] = pick_id;
        end
      end else begin
        // Illegal address still releases the requester but issues nothing.
        err_d = 1'b1;
      end
    end
  end

  // State registers; reset drops any reads still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      a_q   <= '0;
      di_q  <= '0;
      we_q  <= 1'b0;
      re_q  <= 1'b0;
      err_q <= 1'b0;
      pv_q  <= '0;
      pid_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      a_q   <= a_d;
      di_q  <= di_d;
      we_q  <= we_d;
      re_q  <= re_d;
      err_q <= err_d;
      pv_q  <= pv_d;
      pid_q <= pid_d;
    end
  end

  assign bus.ram_a  = a_q;
  assign bus.ram_di = di_q;
  assign bus.ram_we = we_q;
  assign bus.ram_re = re_q;
  assign bus.err    = err_q;
  assign bus.rvld   = pv_q[RDLAT];
  assign bus.rid    = pid_q[RDLAT];
  assign bus.rdat   = bus.ram_do;

endmodule
